sng_bitstream: RTL and testbench
================================

// Module: sng_bitstream
// PURPOSE
//  Stochastic number generator stage downstream of xorwow: consumes the free-running 32-bit rnd word
//  each cycle, compares its top PROB_W bits against a binary probability and emits a unipolar bitstream
//  of programmable length. Can request an upstream reseed (seed/re_seed) before a stream for
//  reproducible streams. Feeds stochastic arithmetic units via bit_valid/bit_out.
// PARAMETERS
//  DATA_W  32  width of rnd_in (matches xorwow rnd)
//  PROB_W  16  probability width; compare uses rnd_in[DATA_W-1 -: PROB_W]
//  LEN_W   16  stream-length width; max stream 2^LEN_W-1 bits
//  SETTLE  2   cycles waited after re_seed_out before first sample (>=1)
// PORTS
//  clk          in   1       clock; all logic rising-edge
//  rst_n        in   1       asynchronous active-low reset
//  rnd_in       in   DATA_W  random word from xorwow rnd, sampled every RUN cycle
//  start        in   1       stream request; accepted only in IDLE
//  prob         in   PROB_W  probability numerator P (p = P/2^PROB_W), latched on accept
//  len          in   LEN_W   stream length in bits, latched on accept
//  reseed_req   in   1       latched on accept; 1 = reseed upstream RNG first
//  seed_in      in   DATA_W  seed, latched on accept
//  seed_out     out  DATA_W  to xorwow seed; holds latched seed
//  re_seed_out  out  1       to xorwow re_seed; one-cycle pulse
//  busy         out  1       high in every non-IDLE state
//  bit_valid    out  1       bit_out qualifier
//  bit_out      out  1       stochastic bit
//  done         out  1       one-cycle pulse, coincident with final bit
//  ones_cnt     out  LEN_W   only with SNG_POPCOUNT_EN
// BEHAVIOUR
//  - Reset (async, any state): state IDLE; seed_out=0, re_seed_out=0, busy=0, bit_valid=0, bit_out=0,
//    done=0, ones_cnt=0, internal counter=0. Reset mid-stream aborts it; no done pulse.
//  - All outputs registered. FSM states: IDLE, SEED, WAIT, RUN.
//  - IDLE: on start=1 at edge T latch prob/len/reseed_req/seed_in.
//    len==0 -> done=1 at T+1 only, no bits, no reseed, stay IDLE (busy stays 0).
//    reseed_req=1 -> SEED; else -> RUN.
//  - SEED (1 cycle): re_seed_out=1, seed_out=latched seed -> WAIT.
//  - WAIT: SETTLE cycles, rnd_in ignored -> RUN.
//  - RUN: every cycle sample rnd_in; next cycle bit_valid=1,
//    bit_out = (rnd_in[DATA_W-1 -: PROB_W] < prob), unsigned compare.
//    Counter loads len on RUN entry, decrements per sample. Sample with counter==1 -> IDLE;
//    done=1 with that final bit. bit_valid high exactly len consecutive cycles, no gaps.
//  - Latency, no reseed: bits at T+2..T+1+len, done at T+1+len, busy low from T+2+len.
//    With reseed: re_seed_out at T+1, first bit at T+3+SETTLE.
//  - prob=0 -> all zeros. prob=2^PROB_W-1 -> ones except when top bits all 1. p=1.0 not representable.
//  - start while busy: ignored, no queueing. start in the done cycle: accepted only if state already IDLE.
//  - prob/len/seed_in changes after accept: no effect on the current stream.
//  - Counter never wraps; len=2^LEN_W-1 must run full length.
// CONFIGURATION
//  SNG_POPCOUNT_EN defined: ones_cnt port present; cleared to 0 on accept; +1 per bit_out=1
//    (same cycle as that bit); holds final popcount from done until next accept.
//  Undefined: ones_cnt port and counter absent; all other behaviour identical.
// TESTING
//  1 rnd_in stub=32'h8000_0000, prob=16'h8000, len=8, start at T
//    -> bit_valid T+2..T+9, bit_out all 0, done only at T+9, busy low at T+10.
//  2 Same rnd_in, prob=16'h8001, len=8 -> eight 1s; ones_cnt=8 at done (SNG_POPCOUNT_EN).
//  3 len=0, start -> done at T+1 only; bit_valid, busy, re_seed_out never assert.
//  4 Integrated xorwow, reseed_req=1, seed_in=32'hDEADBEEF, prob=16'h4000, len=16
//    -> re_seed_out one cycle, seed_out=32'hDEADBEEF; bits match software model; two runs identical.
//  5 start pulsed every cycle during 8-bit stream -> exactly one stream, one done; next accepted only after IDLE.
//  6 rst_n low mid-RUN -> all outputs 0 immediately; no done; fresh start afterwards behaves as scenario 1.

Source files
------------

// File: rtl/sng_bitstream.sv
// rtl/sng_bitstream.sv - stochastic number generator: rnd word vs probability -> unipolar bitstream
// Optional feature macro: SNG_POPCOUNT_EN (adds ones_cnt popcount output)
module sng_bitstream #(
  parameter int DATA_W = 32,
  parameter int PROB_W = 16,
  parameter int LEN_W  = 16,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rnd_in,
  input  logic              start,
  input  logic [PROB_W-1:0] prob,
  input  logic [LEN_W-1:0]  len,
  input  logic              reseed_req,
  input  logic [DATA_W-1:0] seed_in,
  output logic [DATA_W-1:0] seed_out,
  output logic              re_seed_out,
  output logic              busy,
  output logic              bit_valid,
  output logic              bit_out,
`ifdef SNG_POPCOUNT_EN
  output logic [LEN_W-1:0]  ones_cnt,
`endif
  output logic              done
);

  typedef enum logic [1:0] {IDLE, SEED, WAIT, RUN} state_t;

  state_t              state, state_d;
  logic [LEN_W-1:0]    cnt, cnt_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [PROB_W-1:0]   prob_q, prob_d;
  logic [DATA_W-1:0]   seed_d;
  logic                re_seed_d, busy_d, bit_valid_d, bit_out_d, done_d;
  logic                hit;
`ifdef SNG_POPCOUNT_EN
  logic [LEN_W-1:0]    ones_d;
`endif

  // Low rnd bits never take part in the compare.
  logic unused_rnd_lo;
  assign unused_rnd_lo = ^rnd_in[DATA_W-PROB_W-1:0];

  // Unsigned compare of the top rnd bits against the latched probability.
  assign hit = (rnd_in[DATA_W-1 -: PROB_W] < prob_q);

  // State register; reset aborts any stream in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state logic plus next values of all registered outputs and latched operands.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    len_d       = len_q;
    prob_d      = prob_q;
    seed_d      = seed_out;
    re_seed_d   = 1'b0;
    bit_valid_d = 1'b0;
    bit_out_d   = 1'b0;
    done_d      = 1'b0;
`ifdef SNG_POPCOUNT_EN
    ones_d      = ones_cnt;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          prob_d = prob;
          len_d  = len;
          seed_d = seed_in;
`ifdef SNG_POPCOUNT_EN
          ones_d = '0;
`endif
          if (len == '0) begin
            done_d = 1'b1;
          end else if (reseed_req) begin
            state_d   = SEED;
            re_seed_d = 1'b1;
          end else begin
            state_d = RUN;
            cnt_d   = len;
          end
        end
      end
      SEED: begin
        state_d = WAIT;
        cnt_d   = LEN_W'(SETTLE);
      end
      WAIT: begin
        if (cnt == LEN_W'(1)) begin
          state_d = RUN;
          cnt_d   = len_q;
        end else begin
          cnt_d = cnt - LEN_W'(1);
        end
      end
      RUN: begin
        bit_valid_d = 1'b1;
        bit_out_d   = hit;
        cnt_d       = cnt - LEN_W'(1);
`ifdef SNG_POPCOUNT_EN
        ones_d      = ones_cnt + LEN_W'(hit);
`endif
        if (cnt == LEN_W'(1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // busy stays high through the cycle that carries the final bit.
    busy_d = (state_d != IDLE) || (state == RUN);
  end

  // Output, counter and operand registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      len_q       <= '0;
      prob_q      <= '0;
      seed_out    <= '0;
      re_seed_out <= 1'b0;
      busy        <= 1'b0;
      bit_valid   <= 1'b0;
      bit_out     <= 1'b0;
      done        <= 1'b0;
    end else begin
      cnt         <= cnt_d;
      len_q       <= len_d;
      prob_q      <= prob_d;
      seed_out    <= seed_d;
      re_seed_out <= re_seed_d;
      busy        <= busy_d;
      bit_valid   <= bit_valid_d;
      bit_out     <= bit_out_d;
      done        <= done_d;
    end
  end

`ifdef SNG_POPCOUNT_EN
  // Running count of ones in the current stream; holds after done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ones_cnt <= '0;
    else        ones_cnt <= ones_d;
  end
`endif

endmodule

// File: tb/tb_sng_bitstream.sv
// tb/tb_sng_bitstream.sv - directed self-checking bench for sng_bitstream
module tb_sng_bitstream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] rnd_in;
  logic        start = 1'b0;
  logic [15:0] prob = '0;
  logic [15:0] len = '0;
  logic        reseed_req = 1'b0;
  logic [31:0] seed_in = '0;
  logic [31:0] seed_out;
  logic        re_seed_out, busy, bit_valid, bit_out, done;
`ifdef SNG_POPCOUNT_EN
  logic [15:0] ones_cnt;
`endif

  int vec = 0;
  int miss = 0;

  logic        use_xs = 1'b0;
  logic [31:0] xs_q = 32'h1;
  logic [31:0] stub = 32'h8000_0000;

  logic [63:0] bv_m, bo_m, dn_m, bz_m, rs_m;
  logic [31:0] seed1;
  logic [15:0] ones_at_done;

  sng_bitstream dut (
    .clk(clk), .rst_n(rst_n), .rnd_in(rnd_in), .start(start), .prob(prob), .len(len),
    .reseed_req(reseed_req), .seed_in(seed_in), .seed_out(seed_out), .re_seed_out(re_seed_out),
    .busy(busy), .bit_valid(bit_valid), .bit_out(bit_out),
`ifdef SNG_POPCOUNT_EN
    .ones_cnt(ones_cnt),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] xs(input logic [31:0] v);
    logic [31:0] x;
    x = v;
    x = x ^ (x << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x;
  endfunction

  // Stand-in for the upstream xorwow: reseeds on re_seed_out, otherwise free-runs.
  always @(posedge clk) begin
    if (re_seed_out) xs_q <= seed_out;
    else             xs_q <= xs(xs_q);
  end

  assign rnd_in = use_xs ? xs_q : stub;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept a stream at cycle T and record outputs for cycles T+1..T+n (mask bit k = cycle T+k).
  task automatic stream(input logic [15:0] p, input logic [15:0] l, input logic rr,
                        input logic [31:0] s, input int n, input logic hold);
    @(negedge clk);
    start = 1'b1; prob = p; len = l; reseed_req = rr; seed_in = s;
    bv_m = '0; bo_m = '0; dn_m = '0; bz_m = '0; rs_m = '0; ones_at_done = '0; seed1 = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (!hold || k >= 10) start = 1'b0;
      if (!hold) begin
        prob = 16'h0000; len = 16'd3; seed_in = 32'h0; reseed_req = 1'b0;
      end
      bv_m[k] = bit_valid;
      bo_m[k] = bit_out;
      dn_m[k] = done;
      bz_m[k] = busy;
      rs_m[k] = re_seed_out;
      if (k == 1) seed1 = seed_out;
`ifdef SNG_POPCOUNT_EN
      if (done) ones_at_done = ones_cnt;
`endif
    end
  endtask

  function automatic logic [63:0] exp_xs_bits(input logic [31:0] seed);
    logic [63:0] m;
    logic [31:0] x;
    m = '0;
    x = xs(xs(seed));
    for (int k = 0; k < 16; k++) begin
      m[5+k] = (x[31:16] < 16'h4000);
      x = xs(x);
    end
    return m;
  endfunction

  logic [63:0] run_a;
  int          nbv, ndone, done_k;
  logic        busy_after;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {seed_out, 27'b0, re_seed_out, busy, bit_valid, bit_out, done}, 64'h0);
`ifdef SNG_POPCOUNT_EN
    chk("reset_ones", {48'h0, ones_cnt}, 64'h0);
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: top bits 0x8000 vs prob 0x8000 -> all zeros
    stream(16'h8000, 16'd8, 1'b0, 32'h0, 12, 1'b0);
    chk("s1_valid", bv_m, 64'h3FC);
    chk("s1_bits",  bo_m, 64'h0);
    chk("s1_done",  dn_m, 64'h200);
    chk("s1_busy",  bz_m, 64'h3FE);
    chk("s1_reseed", rs_m, 64'h0);
    repeat (2) @(negedge clk);

    // 2: prob 0x8001 -> all ones
    stream(16'h8001, 16'd8, 1'b0, 32'h0, 12, 1'b0);
    chk("s2_valid", bv_m, 64'h3FC);
    chk("s2_bits",  bo_m, 64'h3FC);
    chk("s2_done",  dn_m, 64'h200);
`ifdef SNG_POPCOUNT_EN
    chk("s2_ones", {48'h0, ones_at_done}, 64'd8);
`endif
    repeat (2) @(negedge clk);

    // 3: len 0 -> lone done pulse
    stream(16'h8001, 16'd0, 1'b1, 32'h1234_5678, 12, 1'b0);
    chk("s3_done",  dn_m, 64'h2);
    chk("s3_valid", bv_m, 64'h0);
    chk("s3_busy",  bz_m, 64'h0);
    chk("s3_reseed", rs_m, 64'h0);
    repeat (2) @(negedge clk);

    // 4: reseeded run against the xorshift source, twice
    use_xs = 1'b1;
    stream(16'h4000, 16'd16, 1'b1, 32'hDEAD_BEEF, 24, 1'b0);
    chk("s4_reseed", rs_m, 64'h2);
    chk("s4_seed",  {32'h0, seed1}, 64'hDEAD_BEEF);
    chk("s4_valid", bv_m, 64'h1F_FFE0);
    chk("s4_done",  dn_m, 64'h10_0000);
    chk("s4_busy",  bz_m, 64'h1F_FFFE);
    chk("s4_bits",  bo_m, exp_xs_bits(32'hDEAD_BEEF));
    run_a = bo_m;
    repeat (3) @(negedge clk);
    stream(16'h4000, 16'd16, 1'b1, 32'hDEAD_BEEF, 24, 1'b0);
    chk("s4_repeat", bo_m, run_a);
    use_xs = 1'b0;
    repeat (2) @(negedge clk);

    // 5: start held every cycle; re-accept only in the IDLE done cycle
    stream(16'h8001, 16'd8, 1'b0, 32'h0, 12, 1'b1);
    chk("s5_valid", bv_m, 64'h1BFC);
    chk("s5_done",  dn_m, 64'h200);
    chk("s5_busy",  bz_m, 64'h1FFE);
    repeat (12) @(negedge clk);
    chk("s5_idle", {62'h0, busy, bit_valid}, 64'h0);

    // 6: asynchronous reset in the middle of RUN
    stream(16'h8001, 16'd8, 1'b0, 32'h1234_5678, 4, 1'b0);
    chk("s6_pre_seed", {32'h0, seed_out}, 64'h1234_5678);
    rst_n = 1'b0;
    #1;
    chk("s6_reset_outputs", {seed_out, 27'b0, re_seed_out, busy, bit_valid, bit_out, done}, 64'h0);
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("s6_no_done", 64'(ndone), 64'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    stream(16'h8000, 16'd8, 1'b0, 32'h0, 12, 1'b0);
    chk("s6_valid", bv_m, 64'h3FC);
    chk("s6_done",  dn_m, 64'h200);
    chk("s6_busy",  bz_m, 64'h3FE);
    repeat (2) @(negedge clk);

    // Maximum length stream runs full length without counter wrap
    @(negedge clk);
    start = 1'b1; prob = 16'h8001; len = 16'hFFFF; reseed_req = 1'b0;
    nbv = 0; ndone = 0; done_k = 0; busy_after = 1'b1;
    for (int k = 1; k <= 66000; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (bit_valid) nbv++;
      if (done) begin
        ndone++;
        done_k = k;
`ifdef SNG_POPCOUNT_EN
        ones_at_done = ones_cnt;
`endif
      end
      if (done_k != 0 && k == done_k + 1) begin
        busy_after = busy;
        break;
      end
    end
    chk("max_bits",   64'(nbv), 64'd65535);
    chk("max_done_n", 64'(ndone), 64'd1);
    chk("max_done_at", 64'(done_k), 64'd65536);
    chk("max_busy_off", {63'h0, busy_after}, 64'h0);
`ifdef SNG_POPCOUNT_EN
    chk("max_ones", {48'h0, ones_at_done}, 64'd65535);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
